// File: rtl/coarse_delay_ctrl.sv
// Coarse delay-line controller: saturating up/down code from fine-stage carries, thermometer decode, settle gating, dither lock.
// Latency: one cycle from carry to code/therm/sat; fine_en drops on the step edge and stays low for SETTLE_CYC cycles.
// Backpressure: carries arriving during SETTLE or with coarse_en low are dropped. Optional macro COARSE_GRAY_EN makes coarse_code Gray.
module coarse_delay_ctrl #(
    parameter int COARSE_BITS = 4,
    parameter int INIT_CODE   = 8,
    parameter int SETTLE_CYC  = 4,
    parameter int LOCK_REV    = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        coarse_en,
    input  logic                        carry_incr,
    input  logic                        carry_decr,
    output logic                        fine_en,
    output logic [COARSE_BITS-1:0]      coarse_code,
    output logic [2**COARSE_BITS-2:0]   coarse_therm,
    output logic                        sat_hi,
    output logic                        sat_lo,
    output logic                        locked
);

    localparam int THERM_W = 2**COARSE_BITS - 1;
    localparam int CNT_W   = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int REV_W   = $clog2(LOCK_REV + 1);

    localparam logic [COARSE_BITS-1:0] CODE_MAX  = '1;
    localparam logic [COARSE_BITS-1:0] CODE_MIN  = '0;
    localparam logic [COARSE_BITS-1:0] CODE_INIT = COARSE_BITS'(INIT_CODE);
    localparam logic [CNT_W-1:0]       CNT_LOAD  = CNT_W'(SETTLE_CYC - 1);
    localparam logic [REV_W-1:0]       REV_MAX   = REV_W'(LOCK_REV);

    typedef enum logic {
        ST_TRACK  = 1'b0,
        ST_SETTLE = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DN   = 2'd2
    } dir_t;

    state_t                 state;
    dir_t                   last_dir;
    logic [CNT_W-1:0]       settle_cnt;
    logic [REV_W-1:0]       rev_cnt;
    logic [COARSE_BITS-1:0] code_bin;

    logic                   carry_vld;
    logic                   step_up;
    logic                   step_dn;
    logic                   step;
    logic                   sat_try;
    dir_t                   step_dir;
    logic [COARSE_BITS-1:0] nxt_code;
    logic [REV_W-1:0]       nxt_rev;

    function automatic logic [THERM_W-1:0] therm_of(input logic [COARSE_BITS-1:0] b);
        logic [THERM_W-1:0] t;
        logic [31:0]        bz;
        bz = 32'(b);
        t  = '0;
        for (int i = 0; i < THERM_W; i++) begin
            t[i] = (bz > 32'(i));
        end
        return t;
    endfunction

    function automatic logic [COARSE_BITS-1:0] enc_code(input logic [COARSE_BITS-1:0] b);
`ifdef COARSE_GRAY_EN
        return b ^ (b >> 1);
`else
        return b;
`endif
    endfunction

    // Both carries together is an illegal fine-stage condition and is treated as no carry.
    always_comb begin
        carry_vld = coarse_en && (carry_incr ^ carry_decr) && (state == ST_TRACK);
        step_up   = carry_vld && carry_incr && (code_bin != CODE_MAX);
        step_dn   = carry_vld && carry_decr && (code_bin != CODE_MIN);
        step      = step_up || step_dn;
        sat_try   = carry_vld && !step;
        step_dir  = step_up ? DIR_UP : DIR_DN;

        nxt_code = code_bin;
        if (step_up) begin
            nxt_code = code_bin + 1'b1;
        end else if (step_dn) begin
            nxt_code = code_bin - 1'b1;
        end

        nxt_rev = rev_cnt;
        if (last_dir == DIR_NONE) begin
            nxt_rev = rev_cnt;
        end else if (last_dir != step_dir) begin
            nxt_rev = (rev_cnt == REV_MAX) ? rev_cnt : rev_cnt + 1'b1;
        end else begin
            nxt_rev = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_TRACK;
            settle_cnt   <= '0;
            code_bin     <= CODE_INIT;
            coarse_code  <= enc_code(CODE_INIT);
            coarse_therm <= therm_of(CODE_INIT);
            sat_hi       <= (CODE_INIT == CODE_MAX);
            sat_lo       <= (CODE_INIT == CODE_MIN);
            fine_en      <= 1'b0;
            locked       <= 1'b0;
            rev_cnt      <= '0;
            last_dir     <= DIR_NONE;
        end else begin
            code_bin     <= nxt_code;
            coarse_code  <= enc_code(nxt_code);
            coarse_therm <= therm_of(nxt_code);
            sat_hi       <= (nxt_code == CODE_MAX);
            sat_lo       <= (nxt_code == CODE_MIN);

            case (state)
                ST_TRACK: begin
                    if (step) begin
                        state      <= ST_SETTLE;
                        settle_cnt <= CNT_LOAD;
                        fine_en    <= 1'b0;
                        rev_cnt    <= nxt_rev;
                        locked     <= (nxt_rev == REV_MAX);
                        last_dir   <= step_dir;
                    end else begin
                        fine_en <= coarse_en;
                        if (sat_try) begin
                            rev_cnt  <= '0;
                            locked   <= 1'b0;
                            last_dir <= DIR_NONE;
                        end
                    end
                end
                ST_SETTLE: begin
                    // Counts down regardless of coarse_en so the line always finishes settling.
                    if (settle_cnt == '0) begin
                        state   <= ST_TRACK;
                        fine_en <= coarse_en;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                        fine_en    <= 1'b0;
                    end
                end
                default: begin
                    state   <= ST_TRACK;
                    fine_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_coarse_delay_ctrl.sv
// Bench for coarse_delay_ctrl: directed test-plan steps plus random carries against an integer reference model.
module tb_coarse_delay_ctrl;

    localparam int COARSE_BITS = 4;
    localparam int INIT_CODE   = 8;
    localparam int SETTLE_CYC  = 4;
    localparam int LOCK_REV    = 4;
    localparam int MAX_CODE    = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        coarse_en;
    logic        carry_incr;
    logic        carry_decr;
    logic        fine_en;
    logic [3:0]  coarse_code;
    logic [14:0] coarse_therm;
    logic        sat_hi;
    logic        sat_lo;
    logic        locked;

    int checks = 0;
    int errors = 0;

    // Reference model state: plain integers, direction as +1 / -1 / 0.
    int m_code;
    int m_fine;
    int m_locked;
    int m_rev;
    int m_last;
    int m_settle;

    coarse_delay_ctrl #(
        .COARSE_BITS(COARSE_BITS),
        .INIT_CODE  (INIT_CODE),
        .SETTLE_CYC (SETTLE_CYC),
        .LOCK_REV   (LOCK_REV)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .coarse_en   (coarse_en),
        .carry_incr  (carry_incr),
        .carry_decr  (carry_decr),
        .fine_en     (fine_en),
        .coarse_code (coarse_code),
        .coarse_therm(coarse_therm),
        .sat_hi      (sat_hi),
        .sat_lo      (sat_lo),
        .locked      (locked)
    );

    always #5 clk = ~clk;

    function automatic int expect_code(input int c);
`ifdef COARSE_GRAY_EN
        return c ^ (c >> 1);
`else
        return c;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit r, input bit en, input bit inc, input bit dec);
        int d;
        if (r) begin
            m_code = INIT_CODE; m_fine = 0; m_locked = 0;
            m_rev = 0; m_last = 0; m_settle = 0;
        end else if (m_settle > 0) begin
            m_settle--;
            if (m_settle == 0) m_fine = en;
        end else begin
            m_fine = en;
            if (en && (inc != dec)) begin
                d = inc ? 1 : -1;
                if (m_code + d >= 0 && m_code + d <= MAX_CODE) begin
                    m_code   += d;
                    m_settle = SETTLE_CYC;
                    m_fine   = 0;
                    if (m_last == -d) m_rev = (m_rev < LOCK_REV) ? m_rev + 1 : LOCK_REV;
                    else if (m_last == d) m_rev = 0;
                    m_last   = d;
                    m_locked = (m_rev == LOCK_REV);
                end else begin
                    m_rev = 0; m_locked = 0; m_last = 0;
                end
            end
        end
    endtask

    task automatic cycle(input bit r, input bit en, input bit inc, input bit dec);
        rst = r; coarse_en = en; carry_incr = inc; carry_decr = dec;
        @(posedge clk);
        model_edge(r, en, inc, dec);
        #1;
        chk("code",    32'(coarse_code),  32'(expect_code(m_code)));
        chk("therm",   32'(coarse_therm), 32'((1 << m_code) - 1));
        chk("sat_hi",  32'(sat_hi),       32'(m_code == MAX_CODE));
        chk("sat_lo",  32'(sat_lo),       32'(m_code == 0));
        chk("fine_en", 32'(fine_en),      32'(m_fine));
        chk("locked",  32'(locked),       32'(m_locked));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 1, 0, 0);
    endtask

    task automatic do_reset();
        cycle(1, 1, 0, 0);
        cycle(1, 1, 0, 0);
    endtask

    initial begin
        int fine_low;
        rst = 1'b1; coarse_en = 1'b1; carry_incr = 1'b0; carry_decr = 1'b0;

        // Reset state and release.
        do_reset();
        chk("rst_fine_en", 32'(fine_en), 32'd0);
        chk("rst_therm", 32'(coarse_therm), 32'h00FF);
        idle(1);
        chk("release_fine_en", 32'(fine_en), 32'd1);

        // Single incr, decr during settle ignored, fine_en low for exactly SETTLE_CYC cycles.
        cycle(0, 1, 1, 0);
        chk("incr_therm", 32'(coarse_therm), 32'h01FF);
        fine_low = (fine_en == 1'b0) ? 1 : 0;
        cycle(0, 1, 0, 1);
        if (fine_en == 1'b0) fine_low++;
        for (int i = 0; i < 4; i++) begin
            idle(1);
            if (fine_en == 1'b0) fine_low++;
        end
        chk("settle_len", 32'(fine_low), 32'(SETTLE_CYC));
        chk("decr_in_settle_code", 32'(coarse_code), 32'(expect_code(9)));

        // Saturate upward from INIT: 8th pulse is a no-op with no settle gap.
        do_reset();
        idle(1);
        for (int p = 0; p < 7; p++) begin
            cycle(0, 1, 1, 0);
            idle(SETTLE_CYC);
        end
        chk("sat_hi_set", 32'(sat_hi), 32'd1);
        chk("sat_therm", 32'(coarse_therm), 32'h7FFF);
        cycle(0, 1, 1, 0);
        chk("sat_no_gap", 32'(fine_en), 32'd1);

        // Alternating steps lock on the 5th step; a same-direction step unlocks.
        do_reset();
        idle(1);
        for (int p = 0; p < 5; p++) begin
            cycle(0, 1, (p % 2) == 0, (p % 2) == 1);
            if (p == 4) chk("lock_rise", 32'(locked), 32'd1);
            idle(SETTLE_CYC);
        end
        cycle(0, 1, 1, 0);
        chk("lock_drop", 32'(locked), 32'd0);
        idle(SETTLE_CYC);

        // Both carries together are ignored.
        cycle(0, 1, 1, 1);
        chk("both_fine_en", 32'(fine_en), 32'd1);

        // Reset mid-settle aborts, then tracking resumes next cycle.
        cycle(0, 1, 1, 0);
        idle(1);
        cycle(1, 1, 0, 0);
        chk("rst_mid_settle_code", 32'(coarse_code), 32'(expect_code(8)));
        idle(1);
        chk("rst_mid_settle_fine", 32'(fine_en), 32'd1);

        // Encoding of 8 -> 9 -> 10.
        do_reset();
        idle(1);
        cycle(0, 1, 1, 0);
`ifdef COARSE_GRAY_EN
        chk("enc_9", 32'(coarse_code), 32'hD);
`else
        chk("enc_9", 32'(coarse_code), 32'h9);
`endif
        idle(SETTLE_CYC);
        cycle(0, 1, 1, 0);
`ifdef COARSE_GRAY_EN
        chk("enc_10", 32'(coarse_code), 32'hF);
`else
        chk("enc_10", 32'(coarse_code), 32'hA);
`endif
        idle(SETTLE_CYC);

        // coarse_en low during settle and in track.
        cycle(0, 1, 0, 1);
        cycle(0, 0, 0, 0);
        idle(SETTLE_CYC);
        cycle(0, 0, 1, 0);
        chk("en_low_fine", 32'(fine_en), 32'd0);
        idle(1);

        // Random carries, enables and occasional resets.
        for (int n = 0; n < 3000; n++) begin
            int r;
            int k;
            r = int'($urandom_range(0, 199));
            k = int'($urandom_range(0, 9));
            cycle(r == 0, $urandom_range(0, 9) != 0, k < 3 || k == 9, (k >= 3 && k < 5) || k == 9);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/coarse_delay_ctrl.md
Name: coarse_delay_ctrl

Overview:
Coarse delay-line controller. It sits directly downstream of the fine thermometer shift register and consumes that stage's registered carry_out_incr / carry_out_decr pulses. It keeps a saturating coarse up/down code and decodes it to a thermometer select for the coarse delay cells. It also gates the fine stage's enable while the coarse line settles after each step, and raises a lock flag once the loop dithers stably.

Parameters:
- COARSE_BITS, 4, width of the binary coarse code.
- INIT_CODE, 8, coarse code loaded on reset; must be ≤ 2^COARSE_BITS-1.
- SETTLE_CYC, 4, cycles fine_en is held low after a coarse step (≥1).
- LOCK_REV, 4, consecutive direction reversals required to assert locked (≥2).

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- coarse_en  input  1  enables coarse tracking; when low, carries are ignored and all state holds.
- carry_incr  input  1  one-cycle pulse from the fine stage: wrap past all-ones, step coarse up.
- carry_decr  input  1  one-cycle pulse from the fine stage: wrap past all-zeros, step coarse down.
- fine_en  output  1  registered enable to the fine stage.
- coarse_code  output  COARSE_BITS  registered coarse code (binary, or Gray with the optional feature).
- coarse_therm  output  2^COARSE_BITS-1  registered thermometer select; bit i = 1 iff binary code > i.
- sat_hi  output  1  binary code == 2^COARSE_BITS-1.
- sat_lo  output  1  binary code == 0.
- locked  output  1  stable-dither lock flag.

Behaviour:
- Reset (sync, wins over everything):
  - code = INIT_CODE; coarse_therm decoded from INIT_CODE; sat flags decoded from INIT_CODE.
  - fine_en = 0, locked = 0, reversal count = 0, last direction = NONE, state = TRACK.
  - rst asserted mid-SETTLE aborts the settle immediately.
- FSM states:
  - TRACK:
    - fine_en is registered as coarse_en, so it is 1 the cycle after reset releases if coarse_en = 1.
    - A valid step is sampled when coarse_en=1 and exactly one carry is high.
  - SETTLE:
    - Entered on the edge that applies a step. fine_en goes 0 on that same edge.
    - Counter loads SETTLE_CYC-1 and decrements each cycle. At 0, return to TRACK; fine_en goes 1 on that edge.
    - fine_en is therefore low for exactly SETTLE_CYC cycles.
    - All carries are ignored in SETTLE.
- Step application (TRACK):
  - incr, code < max: code+1.
  - decr, code > 0: code-1.
  - New code, coarse_therm and sat flags all update on the same edge (1-cycle latency from the carry).
- Saturation:
  - incr at max, or decr at 0: code unchanged, no SETTLE entry, fine_en stays 1.
  - Reversal count cleared, locked cleared, last direction = NONE.
- Simultaneous carry_incr and carry_decr: illegal from the fine stage. Ignored entirely; no code, lock or FSM change.
- Lock tracking (on applied steps only):
  - Direction opposite to last direction: reversal count += 1, saturating at LOCK_REV.
  - Same direction as last direction: count = 0, locked = 0.
  - locked = 1 on the edge the count reaches LOCK_REV. It stays 1 until a same-direction step, a saturated attempt, or rst.
- coarse_en low:
  - fine_en = 0 next edge.
  - Code, lock state and count hold.
  - A SETTLE in progress keeps counting down.

Optional Feature:
- Macro COARSE_GRAY_EN.
- Defined: coarse_code carries the Gray encoding (b ^ (b>>1)) of the internal binary code, registered on the same edge as the binary update (no added latency). Saturation, thermometer and lock logic still use binary internally.
- Not defined: coarse_code is plain binary.

Test Plan:
- Reset then idle, coarse_en=1: code=8, therm=0x00FF, sat_hi=0, sat_lo=0, locked=0; fine_en=0 during rst, 1 the first cycle after release.
- Single carry_incr pulse in TRACK: code 8→9 next edge, therm=0x01FF; fine_en low for exactly 4 cycles then high; a carry_decr pulse injected during those 4 cycles leaves code=9.
- Eight incr pulses, each after settle, from 8: code saturates at 15, sat_hi=1, therm=0x7FFF; the 8th pulse causes no change and no settle gap (fine_en stays 1).
- Alternating incr,decr,incr,decr,incr after settles: locked rises on the edge of the 5th step (4th reversal); a following same-direction step drops locked to 0.
- carry_incr and carry_decr high together in TRACK: no change to code, fine_en, locked; rst asserted mid-SETTLE: code=8, fine_en=0, state TRACK next edge.
- With COARSE_GRAY_EN: steps 8→9→10 give coarse_code 0xC→0xD→0xF; without it 0x8→0x9→0xA.
